// File: rtl/writeback_queue.sv
// Write-back queue: merges ALU and load results into one register-file write port.
// Optional macro WRITEBACK_BYPASS_EN forwards the first accepted entry straight out when the queue is empty.
module writeback_queue #(
  parameter int OPERAND_WIDTH             = 32,
  parameter int REGISTER_DESCRIPTOR_WIDTH = 4,
  parameter int QUEUE_DEPTH               = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 alu_valid_input,
  output logic                                 alu_ready_output,
  input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] alu_register_input,
  input  logic [OPERAND_WIDTH-1:0]             alu_result_input,
  input  logic                                 mem_valid_input,
  output logic                                 mem_ready_output,
  input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] mem_register_input,
  input  logic [OPERAND_WIDTH-1:0]             mem_result_input,
  output logic                                 write_back_output,
  output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] write_back_register_output,
  output logic [OPERAND_WIDTH-1:0]             result_output,
  input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] query_register_input,
  output logic                                 pending_output,
  output logic [$clog2(QUEUE_DEPTH):0]         count_output
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = REGISTER_DESCRIPTOR_WIDTH;
  localparam int OW = OPERAND_WIDTH;
  localparam logic [CW-1:0] DEPTH_C    = CW'(QUEUE_DEPTH);
  localparam logic [CW-1:0] DEPTH_M1_C = CW'(QUEUE_DEPTH - 1);

  logic [CW-1:0] count_q;
  logic [PW-1:0] rd_ptr, wr_ptr, wr_ptr_nx;
  logic [RW-1:0] reg_mem  [QUEUE_DEPTH];
  logic [OW-1:0] data_mem [QUEUE_DEPTH];

  logic          mem_push, alu_push, empty, bypass, pop;
  logic [1:0]    n_store;
  logic [RW-1:0] first_reg, store_reg;
  logic [OW-1:0] first_data, store_data;

  always_comb begin
    mem_ready_output = count_q < DEPTH_C;
    alu_ready_output = (count_q < DEPTH_M1_C) || (mem_ready_output && !mem_valid_input);
    mem_push   = mem_valid_input && mem_ready_output;
    alu_push   = alu_valid_input && alu_ready_output;
    empty      = (count_q == '0);
    pop        = !empty;
    // Mem is ordered ahead of the ALU whenever both transfer together.
    first_reg  = mem_push ? mem_register_input : alu_register_input;
    first_data = mem_push ? mem_result_input   : alu_result_input;
`ifdef WRITEBACK_BYPASS_EN
    bypass     = empty && (mem_push || alu_push);
`else
    bypass     = 1'b0;
`endif
    // A bypassed first entry leaves only the ALU entry (if any) to store.
    store_reg  = bypass ? alu_register_input : first_reg;
    store_data = bypass ? alu_result_input   : first_data;
    n_store    = {1'b0, mem_push} + {1'b0, alu_push} - {1'b0, bypass};
    wr_ptr_nx  = wr_ptr + PW'(1);
  end

  always_comb begin
    write_back_output          = 1'b0;
    write_back_register_output = '0;
    result_output              = '0;
    if (!empty) begin
      write_back_output          = 1'b1;
      write_back_register_output = reg_mem[rd_ptr];
      result_output              = data_mem[rd_ptr];
    end else if (bypass) begin
      write_back_output          = 1'b1;
      write_back_register_output = first_reg;
      result_output              = first_data;
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    pending_output = 1'b0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if ((CW'(PW'(i) - rd_ptr) < count_q) && (reg_mem[i] == query_register_input))
        pending_output = 1'b1;
    end
  end

  assign count_output = count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      count_q <= count_q + CW'(n_store) - CW'(pop);
      wr_ptr  <= wr_ptr + PW'(n_store);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (n_store != 2'd0) begin
      reg_mem[wr_ptr]  <= store_reg;
      data_mem[wr_ptr] <= store_data;
    end
    if (n_store == 2'd2) begin
      reg_mem[wr_ptr_nx]  <= alu_register_input;
      data_mem[wr_ptr_nx] <= alu_result_input;
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed self-checking bench for writeback_queue; expectations cover both the plain and bypass builds.
module tb_writeback_queue;

`ifdef WRITEBACK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic        alu_ready, mem_ready;
  logic [3:0]  alu_reg = '0, mem_reg = '0, query = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic        wb, pending;
  logic [3:0]  wb_reg;
  logic [31:0] wb_data;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  writeback_queue #(.OPERAND_WIDTH(32), .REGISTER_DESCRIPTOR_WIDTH(4), .QUEUE_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid_input(alu_valid), .alu_ready_output(alu_ready),
    .alu_register_input(alu_reg), .alu_result_input(alu_data),
    .mem_valid_input(mem_valid), .mem_ready_output(mem_ready),
    .mem_register_input(mem_reg), .mem_result_input(mem_data),
    .write_back_output(wb), .write_back_register_output(wb_reg), .result_output(wb_data),
    .query_register_input(query), .pending_output(pending), .count_output(count)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit reached;
    #2;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (wb !== 1'b0 || wb_reg !== 4'd0 || wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb: got wb=%b reg=%0d data=%h expected 0/0/0", wb, wb_reg, wb_data); end
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got alu=%b mem=%b expected 1/1", alu_ready, mem_ready); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", pending); end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    // Fill to three entries, then pull reset mid-cycle.
    reached = 1'b0;
    query = 4'd2;
    for (int k = 0; k < 6; k++) begin
      mem_valid = 1'b1; mem_reg = 4'd2; mem_data = 32'h10 + k;
      alu_valid = 1'b1; alu_reg = 4'd6; alu_data = 32'h20 + k;
      @(negedge clk);
      if (count == 3'd3) begin reached = 1'b1; break; end
      next_cycle();
    end
    checks++; if (reached !== 1'b1) begin errors++; $display("FAIL reset_fill: got count=%0d expected 3", count); end
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL reset_pre_pending: got %b expected 1", pending); end
    idle();
    rst = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_mid_count: got %0d expected 0", count); end
    checks++; if (wb !== 1'b0 || wb_reg !== 4'd0 || wb_data !== 32'd0) begin errors++; $display("FAIL reset_mid_wb: got wb=%b reg=%0d data=%h expected 0/0/0", wb, wb_reg, wb_data); end
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1 || pending !== 1'b0) begin errors++; $display("FAIL reset_mid_ctl: got alu=%b mem=%b pend=%b expected 1/1/0", alu_ready, mem_ready, pending); end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (count !== 3'd0 || wb !== 1'b0) begin errors++; $display("FAIL reset_release: got count=%0d wb=%b expected 0/0", count, wb); end
    next_cycle();
  endtask

  task automatic test_single_alu();
    alu_valid = 1'b1; alu_reg = 4'd5; alu_data = 32'h1234;
    @(negedge clk);
    checks++; if (wb !== BYP || wb_reg !== (BYP ? 4'd5 : 4'd0) || wb_data !== (BYP ? 32'h1234 : 32'h0)) begin errors++; $display("FAIL single_c0: got wb=%b reg=%0d data=%h expected %b", wb, wb_reg, wb_data, BYP); end
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (wb !== !BYP || wb_reg !== (BYP ? 4'd0 : 4'd5) || wb_data !== (BYP ? 32'h0 : 32'h1234)) begin errors++; $display("FAIL single_c1: got wb=%b reg=%0d data=%h expected %b", wb, wb_reg, wb_data, !BYP); end
    checks++; if (count !== (BYP ? 3'd0 : 3'd1)) begin errors++; $display("FAIL single_c1_count: got %0d expected %0d", count, BYP ? 0 : 1); end
    next_cycle();
    @(negedge clk);
    checks++; if (wb !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL single_c2: got wb=%b count=%0d expected 0/0", wb, count); end
    next_cycle();
  endtask

  task automatic test_dual_push();
    mem_valid = 1'b1; mem_reg = 4'd3; mem_data = 32'hAAAA;
    alu_valid = 1'b1; alu_reg = 4'd7; alu_data = 32'hBBBB;
    @(negedge clk);
    checks++; if (wb !== BYP || wb_reg !== (BYP ? 4'd3 : 4'd0)) begin errors++; $display("FAIL dual_c0: got wb=%b reg=%0d expected %b", wb, wb_reg, BYP); end
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (wb !== 1'b1 || wb_reg !== (BYP ? 4'd7 : 4'd3) || wb_data !== (BYP ? 32'hBBBB : 32'hAAAA)) begin errors++; $display("FAIL dual_c1: got wb=%b reg=%0d data=%h", wb, wb_reg, wb_data); end
    checks++; if (count !== (BYP ? 3'd1 : 3'd2)) begin errors++; $display("FAIL dual_peak: got %0d expected %0d", count, BYP ? 1 : 2); end
    next_cycle();
    @(negedge clk);
    checks++; if (wb !== !BYP || wb_reg !== (BYP ? 4'd0 : 4'd7) || wb_data !== (BYP ? 32'h0 : 32'hBBBB)) begin errors++; $display("FAIL dual_c2: got wb=%b reg=%0d data=%h", wb, wb_reg, wb_data); end
    next_cycle();
    @(negedge clk);
    checks++; if (wb !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL dual_c3: got wb=%b count=%0d expected 0/0", wb, count); end
    next_cycle();
  endtask

  // Write-back codes: 0 idle, 1..4 = mem entry 0..3, 5..8 = alu entry 0..3.
  task automatic test_fill();
    int exp_ar[8], exp_cnt[8], exp_wb[8];
    int mi, ai, code;
    logic [3:0]  ereg;
    logic [31:0] edata;
    if (BYP) begin
      exp_ar = '{1, 1, 1, 0, 1, 1, 1, 1}; exp_cnt = '{0, 1, 2, 3, 3, 2, 1, 0}; exp_wb = '{1, 5, 2, 6, 3, 7, 4, 0};
    end else begin
      exp_ar = '{1, 1, 0, 0, 1, 1, 1, 1}; exp_cnt = '{0, 2, 3, 3, 3, 2, 1, 0}; exp_wb = '{0, 1, 5, 2, 6, 3, 4, 0};
    end
    mi = 0; ai = 0;
    for (int c = 0; c < 8; c++) begin
      mem_valid = (c < 4); mem_reg = 4'(1 + mi); mem_data = 32'h100 + 32'(mi);
      alu_valid = (c < 4); alu_reg = 4'(8 + ai); alu_data = 32'h200 + 32'(ai);
      @(negedge clk);
      code  = exp_wb[c];
      ereg  = (code == 0) ? 4'd0 : (code <= 4) ? 4'(code) : 4'(code + 3);
      edata = (code == 0) ? 32'h0 : (code <= 4) ? 32'h100 + 32'(code - 1) : 32'h200 + 32'(code - 5);
      checks++; if (mem_ready !== 1'b1 || alu_ready !== exp_ar[c][0]) begin errors++; $display("FAIL fill_ready c%0d: got mem=%b alu=%b expected 1/%0d", c, mem_ready, alu_ready, exp_ar[c]); end
      checks++; if (count !== 3'(exp_cnt[c])) begin errors++; $display("FAIL fill_count c%0d: got %0d expected %0d", c, count, exp_cnt[c]); end
      checks++; if (wb !== (code != 0) || wb_reg !== ereg || wb_data !== edata) begin errors++; $display("FAIL fill_wb c%0d: got wb=%b reg=%0d data=%h expected reg=%0d data=%h", c, wb, wb_reg, wb_data, ereg, edata); end
      if (mem_valid) mi++;
      if (alu_valid && exp_ar[c] == 1) ai++;
      next_cycle();
    end
    idle();
  endtask

  task automatic test_pending();
    int exp_p[5];
    if (BYP) exp_p = '{0, 0, 1, 0, 0};
    else     exp_p = '{0, 0, 1, 1, 0};
    query = 4'd9;
    for (int c = 0; c < 5; c++) begin
      idle();
      if (c == 0) begin
        mem_valid = 1'b1; mem_reg = 4'd1; mem_data = 32'h11;
        alu_valid = 1'b1; alu_reg = 4'd2; alu_data = 32'h22;
      end else if (c == 1) begin
        alu_valid = 1'b1; alu_reg = 4'd9; alu_data = 32'h99;
      end
      #1;
      @(negedge clk);
      checks++; if (pending !== exp_p[c][0]) begin errors++; $display("FAIL pending_r9 c%0d: got %b expected %0d", c, pending, exp_p[c]); end
      query = 4'd10;
      #1;
      checks++; if (pending !== 1'b0) begin errors++; $display("FAIL pending_r10 c%0d: got %b expected 0", c, pending); end
      query = 4'd9;
      if (c == 2) begin
        checks++; if (wb_reg !== (BYP ? 4'd9 : 4'd2)) begin errors++; $display("FAIL pending_wb c2: got reg=%0d expected %0d", wb_reg, BYP ? 9 : 2); end
      end
      next_cycle();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_dual_push();
    test_fill();
    test_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1);
  end

endmodule
